uart_tx_buffered: RTL and testbench
===================================

Name: uart_tx_buffered

Overview:
- 8N1 UART transmitter; the transmit-side counterpart of the UART receive path.
- Takes bytes over a valid/ready handshake into a 1-deep holding register, then serialises them LSB-first onto the TX line.
- Baud timing is clock-count based and uses the same p_CLKs_PB convention as the receiver, so RX and TX instances share one parameter value.
- Sits between the byte source (loopback from the RX byte, test pattern generator) and the board TX pin.

Parameters:
- p_CLKs_PB, 217, clocks per bit; legal range is >= 2, and elaboration fails otherwise.

Ports:
- i_Clk  input  1  system clock; the only clock.
- i_Reset  input  1  synchronous, active-high reset.
- i_Tx_Byte  input  8  byte to send; sampled only when i_Tx_Valid && o_Tx_Ready.
- i_Tx_Valid  input  1  source has a byte on i_Tx_Byte.
- o_Tx_Ready  output  1  holding register empty; a byte can be accepted this cycle.
- o_Tx_Serial  output  1  UART line; idles high.
- o_Tx_Active  output  1  high while a frame (start, data or stop bit) is on the line.
- o_Tx_Done  output  1  one-cycle pulse on the last clock of each stop bit.

Behaviour:
- Reset values (at the first edge with i_Reset=1):
  - o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0, o_Tx_Done=0.
  - Holding register cleared; state IDLE; baud counter 0; bit index 0.
- Reset mid-frame: the frame is aborted, the line returns high after the reset edge, and any held byte is discarded.
- Handshake:
  - Accept occurs on an edge where i_Tx_Valid && o_Tx_Ready; the byte is latched into the holding register.
  - o_Tx_Ready is low from the following cycle until the shifter takes the byte.
  - Valid may stay high across cycles; exactly one byte is taken per accept.
- Shifter load:
  - Happens on an edge where the holding register is full and the state is IDLE, or the state is STOP with the counter at p_CLKs_PB-1.
  - The load clears the holding register, so o_Tx_Ready returns high on the next cycle.
- Latency: accept at edge k with the shifter IDLE -> load at edge k+1 -> o_Tx_Serial=0 from edge k+1 for p_CLKs_PB clocks.
- State machine (baud counter runs 0..p_CLKs_PB-1; each bit is held exactly p_CLKs_PB clocks):
  - IDLE: line high. On load -> START.
  - START: line low. At count p_CLKs_PB-1 -> DATA, with bit index 0.
  - DATA: line = shift[bit index]. At count p_CLKs_PB-1, increment the index; after index 7 -> STOP.
  - STOP: line high. At count p_CLKs_PB-1, pulse o_Tx_Done. If the holding register is full, load and go directly to START (back-to-back frames with no idle gap); otherwise go to IDLE.
- Frame length is exactly 10*p_CLKs_PB clocks.
- o_Tx_Active is 1 in START, DATA and STOP, and 0 in IDLE.
- Bytes are shifted LSB first.
- Widths:
  - Counter width is $clog2(p_CLKs_PB); it wraps to 0 at every bit boundary and never overflows.
  - Bit index is 3 bits.
- Simultaneous events:
  - Accept and load cannot coincide, because ready=0 whenever the holding register is full.
  - The holding register can be refilled while a frame is in flight; at most 2 bytes are outstanding (shifter plus holding).
- The line output is registered: no combinational path from any input to o_Tx_Serial.

Decomposition:
- Package uart_pkg:
  - c_DATA_BITS=8.
  - State enum t_uart_tx_state {IDLE, START, DATA, STOP}.
  - The RX block's state enum moves here as well.
- Sub-module uart_baud_counter:
  - Takes p_CLKs_PB.
  - Inputs: i_Clk, i_Reset, i_Clear.
  - Output: o_Bit_End, high when count = p_CLKs_PB-1.
  - Reusable by the RX block.
- The top-level board wrapper (loopback RX->TX) is separate and out of scope here.

Test Plan (p_CLKs_PB=4 unless noted):
- Reset, then idle 50 clocks -> o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0, no o_Tx_Done pulse.
- Single byte: accept 0x55 at edge k -> line low during k+1..k+4, then bits 1,0,1,0,1,0,1,0 for 4 clocks each, then high for 4 clocks; o_Tx_Done at clock k+40; o_Tx_Ready=1 again from k+2.
- Back-to-back: 0xA3 then 0x0F with i_Tx_Valid held high -> 2nd byte accepted at ready; 20 consecutive bit periods with no idle gap; start bit of 0x0F begins the clock after 0xA3's stop ends; 2 o_Tx_Done pulses 40 clocks apart.
- Backpressure: with the shifter busy and holding full, present 0x77 -> o_Tx_Ready=0; 0x77 is not taken until the stop edge; a 3rd byte driven meanwhile is not sampled.
- Reset mid-frame: assert i_Reset during DATA bit 3 of 0xFF with 0x12 held -> line high after the reset edge, ready=1, no o_Tx_Done; a fresh 0x12 then sends correctly.
- Loopback: p_CLKs_PB=217, TX output into the UART RX block, send 0x00, 0xFF, 0x5A, 0xC3 -> RX reports identical bytes in order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the TX/RX state encodings.
package uart_pkg;

  localparam int unsigned c_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } t_uart_tx_state;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_CLEANUP
  } t_uart_rx_state;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: runs 0..p_CLKs_PB-1 and flags the last clock of each bit.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned p_CLKs_PB = 217
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Clear,
  output logic o_Bit_End
);

  localparam int unsigned CntW = (p_CLKs_PB > 1) ? $clog2(p_CLKs_PB) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(p_CLKs_PB - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign o_Bit_End = (cnt_q == CntMax);

  // Wrap at the bit boundary so the counter never needs to exceed p_CLKs_PB-1.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (i_Clear || o_Bit_End) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter with a 1-deep holding register in front of the shifter.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned p_CLKs_PB = 217
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [7:0] i_Tx_Byte,
  input  logic       i_Tx_Valid,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done
);

  if (p_CLKs_PB < 2) begin : g_bad_clks_pb
    $error("uart_tx_buffered: p_CLKs_PB must be at least 2");
  end

  localparam logic [2:0] LastIdx = 3'(c_DATA_BITS - 1);

  t_uart_tx_state   state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       idx_q, idx_d;
  logic             serial_q, serial_d;
  logic             bit_end;
  logic             accept;
  logic             load;

  uart_baud_counter #(
    .p_CLKs_PB (p_CLKs_PB)
  ) u_baud (
    .i_Clk     (i_Clk),
    .i_Reset   (i_Reset),
    .i_Clear   (state_q == IDLE),
    .o_Bit_End (bit_end)
  );

  // Ready is low whenever the holding register is full, so accept and load never coincide.
  assign accept = i_Tx_Valid && !hold_full_q;
  assign load   = hold_full_q && ((state_q == IDLE) || ((state_q == STOP) && bit_end));

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    idx_d       = idx_q;

    if (accept) begin
      hold_d      = i_Tx_Byte;
      hold_full_d = 1'b1;
    end
    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == LastIdx) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = load ? START : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is derived from the next state so it can be registered.
    unique case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[idx_d];
      default: serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      idx_q       <= '0;
      serial_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      serial_q    <= serial_d;
    end
  end

  assign o_Tx_Ready  = !hold_full_q;
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = (state_q != IDLE);
  assign o_Tx_Done   = (state_q == STOP) && bit_end;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: fast instance (4 clk/bit) plus a 217 clk/bit loopback.
module tb_uart_tx_buffered;

  localparam int TbP  = 4;
  localparam int LbP  = 217;
  localparam int Hist = 128;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready, tx_serial, tx_active, tx_done;
  logic [7:0] lb_byte;
  logic       lb_valid;
  logic       lb_ready, lb_serial, lb_active, lb_done;

  int n_checks = 0;
  int n_errors = 0;

  logic line_h   [Hist];
  logic done_h   [Hist];
  logic ready_h  [Hist];
  logic active_h [Hist];
  int   cap_n;

  always #5 clk = ~clk;

  uart_tx_buffered #(.p_CLKs_PB(TbP)) dut (
    .i_Clk       (clk),
    .i_Reset     (rst),
    .i_Tx_Byte   (tx_byte),
    .i_Tx_Valid  (tx_valid),
    .o_Tx_Ready  (tx_ready),
    .o_Tx_Serial (tx_serial),
    .o_Tx_Active (tx_active),
    .o_Tx_Done   (tx_done)
  );

  uart_tx_buffered #(.p_CLKs_PB(LbP)) dut_lb (
    .i_Clk       (clk),
    .i_Reset     (rst),
    .i_Tx_Byte   (lb_byte),
    .i_Tx_Valid  (lb_valid),
    .o_Tx_Ready  (lb_ready),
    .o_Tx_Serial (lb_serial),
    .o_Tx_Active (lb_active),
    .o_Tx_Done   (lb_done)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each capture slot holds the outputs sampled just after one clock edge.
  task automatic cap(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (cap_n < Hist) begin
        line_h[cap_n]   = tx_serial;
        done_h[cap_n]   = tx_done;
        ready_h[cap_n]  = tx_ready;
        active_h[cap_n] = tx_active;
      end
      cap_n++;
    end
  endtask

  function automatic logic [39:0] frame_exp(input logic [7:0] b);
    logic [39:0] f;
    for (int j = 0; j < 10 * TbP; j++) begin
      int k = j / TbP;
      f[j] = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
    end
    return f;
  endfunction

  function automatic logic [39:0] line_at(input int base);
    logic [39:0] v;
    for (int j = 0; j < 40; j++) v[j] = line_h[base + j];
    return v;
  endfunction

  function automatic logic [39:0] done_at(input int base);
    logic [39:0] v;
    for (int j = 0; j < 40; j++) v[j] = done_h[base + j];
    return v;
  endfunction

  task automatic send_one(input logic [7:0] b, input string tag);
    tx_byte  = b;
    tx_valid = 1'b1;
    tick();
    check_eq({tag, "_ready_low"}, tx_ready, 1'b0);
    tx_valid = 1'b0;
    cap_n    = 0;
    cap(41);
    check_eq({tag, "_ready_back"}, ready_h[0], 1'b1);
    check_eq({tag, "_line"}, line_at(0), frame_exp(b));
    check_eq({tag, "_done"}, done_at(0), 40'h1 << 39);
    check_eq({tag, "_idle_after"}, {line_h[40], active_h[40]}, 2'b10);
  endtask

  task automatic lb_send(input logic [7:0] b, input string tag);
    logic [7:0] got;
    int t;
    lb_byte  = b;
    lb_valid = 1'b1;
    tick();
    lb_valid = 1'b0;
    t = 0;
    while (lb_serial !== 1'b0 && t < 500) begin
      tick();
      t++;
    end
    check_eq({tag, "_start_seen"}, lb_serial, 1'b0);
    repeat (LbP / 2) tick();
    for (int i = 0; i < 8; i++) begin
      repeat (LbP) tick();
      got[i] = lb_serial;
    end
    repeat (LbP) tick();
    check_eq({tag, "_stop"}, lb_serial, 1'b1);
    check_eq({tag, "_byte"}, got, b);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    rst      = 1'b1;
    tx_byte  = 8'h00;
    tx_valid = 1'b0;
    lb_byte  = 8'h00;
    lb_valid = 1'b0;

    tick();
    check_eq("rst_outputs", {tx_serial, tx_ready, tx_active, tx_done}, 4'b1100);
    tick();
    rst = 1'b0;

    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tx_serial !== 1'b1 || tx_ready !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0)
        bad++;
    end
    check_eq("idle50", bad, 0);

    send_one(8'h55, "byte55");

    // Back-to-back with valid held: second byte waits in the holding register.
    tx_byte  = 8'hA3;
    tx_valid = 1'b1;
    tick();
    tx_byte = 8'h0F;
    cap_n   = 0;
    cap(2);
    tx_valid = 1'b0;
    check_eq("b2b_hold_full", tx_ready, 1'b0);
    cap(79);
    check_eq("b2b_line_a3", line_at(0), frame_exp(8'hA3));
    check_eq("b2b_line_0f", line_at(40), frame_exp(8'h0F));
    check_eq("b2b_done_a3", done_at(0), 40'h1 << 39);
    check_eq("b2b_done_0f", done_at(40), 40'h1 << 39);
    check_eq("b2b_idle_after", {line_h[80], active_h[80]}, 2'b10);

    // Backpressure: 0x77 parked while 0x3C shifts; 0x99 must never be taken.
    tx_byte  = 8'h3C;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    cap_n    = 0;
    cap(1);
    tx_byte  = 8'h77;
    tx_valid = 1'b1;
    cap(1);
    tx_byte = 8'h99;
    cap(38);
    bad = 0;
    for (int j = 1; j < 40; j++) if (ready_h[j] !== 1'b0) bad++;
    check_eq("bp_ready_low", bad, 0);
    cap(1);
    check_eq("bp_ready_at_stop", tx_ready, 1'b1);
    tx_valid = 1'b0;
    cap(40);
    check_eq("bp_line_3c", line_at(0), frame_exp(8'h3C));
    check_eq("bp_line_77", line_at(40), frame_exp(8'h77));
    check_eq("bp_idle_after", {line_h[80], active_h[80], ready_h[80]}, 3'b101);

    // Reset during data bit 3 of 0xFF with 0x12 held.
    tx_byte  = 8'hFF;
    tx_valid = 1'b1;
    tick();
    tx_byte = 8'h12;
    tick();
    tick();
    tx_valid = 1'b0;
    repeat (16) tick();
    check_eq("midrst_bit3", {tx_serial, tx_active, tx_ready}, 3'b110);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_outputs", {tx_serial, tx_ready, tx_active, tx_done}, 4'b1100);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tx_serial !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    check_eq("midrst_quiet", bad, 0);
    send_one(8'h12, "byte12");

    lb_send(8'h00, "lb00");
    lb_send(8'hFF, "lbFF");
    lb_send(8'h5A, "lb5A");
    lb_send(8'hC3, "lbC3");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
